// File: rtl/vector_serializer.sv
// vector_serializer
//   Captures one WORDS*WIDTH-bit vector and streams it out one WIDTH-bit
//   word per transfer, lowest word first, with a valid/ready handshake on
//   both sides. A new vector can be accepted on the cycle the last beat
//   transfers, so back-to-back frames have no bubble.
//
//   Optional build macro: VECTOR_SERIALIZER_HEADER_EN
//     When defined, each frame is preceded by a header beat
//     {8'hA5, 8'h00, 16'(WORDS)}, giving WORDS+1 beats per frame.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            synchronous active-high reset
//   in_heard__ENA  upstream delivers a vector this cycle
//   in_heard_v     vector payload, word k at [k*WIDTH +: WIDTH]
//   in_heard__RDY  block can accept a vector this cycle
//   out_word__ENA  one output word transfers this cycle
//   out_word_v     current output word
//   out_word_last  current word is the final beat of the frame
//   out_word__RDY  downstream can take a word this cycle

module vector_serializer #(
  parameter int unsigned WORDS = 22,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_heard__ENA,
  input  logic [WORDS*WIDTH-1:0] in_heard_v,
  output logic                   in_heard__RDY,
  output logic                   out_word__ENA,
  output logic [WIDTH-1:0]       out_word_v,
  output logic                   out_word_last,
  input  logic                   out_word__RDY
);

`ifdef VECTOR_SERIALIZER_HEADER_EN
  localparam int unsigned BEATS = WORDS + 1;
`else
  localparam int unsigned BEATS = WORDS;
`endif
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [WORDS*WIDTH-1:0] vec;
  logic                   capture;
  logic                   at_last;
  logic [WIDTH-1:0]       beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Payload register carries no reset; capture is forced low during RST.
  always_ff @(posedge CLK) begin
    if (capture) begin
      vec <= in_heard_v;
    end
  end

  // Beat selection from the held vector (header occupies index 0 when enabled).
  always_comb begin
    beat = '0;
`ifdef VECTOR_SERIALIZER_HEADER_EN
    if (idx == '0) begin
      beat = WIDTH'({8'hA5, 8'h00, 16'(WORDS)});
    end else begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (32'(idx) == k + 1) begin
          beat = vec[k*WIDTH +: WIDTH];
        end
      end
    end
`else
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (32'(idx) == k) begin
        beat = vec[k*WIDTH +: WIDTH];
      end
    end
`endif
  end

  assign at_last = (idx == LAST_IDX);

  // All handshake outputs are gated by RST so nothing is offered or
  // accepted while reset is held, whatever state the register holds.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    capture       = 1'b0;
    in_heard__RDY = 1'b0;
    out_word__ENA = 1'b0;
    out_word_v    = '0;
    out_word_last = 1'b0;

    if (!RST) begin
      case (state)
        IDLE: begin
          in_heard__RDY = 1'b1;
          if (in_heard__ENA) begin
            capture   = 1'b1;
            idx_nxt   = '0;
            state_nxt = SEND;
          end
        end
        SEND: begin
          out_word__ENA = out_word__RDY;
          out_word_v    = beat;
          out_word_last = at_last;
          in_heard__RDY = at_last && out_word__RDY;
          if (out_word__RDY) begin
            if (at_last) begin
              idx_nxt = '0;
              if (in_heard__ENA) begin
                capture = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer
//   Directed, table-driven bench for vector_serializer. Each table row holds
//   the inputs for one cycle and the outputs expected in that cycle; rows are
//   driven on the falling edge and checked 1ns later. A hand-written sequence
//   covers reset asserted in the middle of a frame.
//   Build with VECTOR_SERIALIZER_HEADER_EN to exercise the header beat.

module tb_vector_serializer;

  localparam int unsigned WORDS = 22;
  localparam int unsigned WIDTH = 32;
`ifdef VECTOR_SERIALIZER_HEADER_EN
  localparam int unsigned HDR = 1;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam int unsigned BEATS = WORDS + HDR;

  logic                   CLK;
  logic                   RST;
  logic                   in_ena;
  logic [WORDS*WIDTH-1:0] in_v;
  logic                   in_rdy;
  logic                   out_ena;
  logic [WIDTH-1:0]       out_v;
  logic                   out_last;
  logic                   out_rdy;

  vector_serializer #(
    .WORDS(WORDS),
    .WIDTH(WIDTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_heard__ENA(in_ena),
    .in_heard_v   (in_v),
    .in_heard__RDY(in_rdy),
    .out_word__ENA(out_ena),
    .out_word_v   (out_v),
    .out_word_last(out_last),
    .out_word__RDY(out_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [15:0] base;
    logic        rdy;
    logic        chk_v;
    logic        exp_in_rdy;
    logic        exp_out_ena;
    logic [31:0] exp_v;
    logic        exp_last;
  } row_t;

  row_t tbl[200];
  int   n_rows;
  int   total;
  int   bad;

  // Expected word on beat j of a frame whose data word k is base+k.
  function automatic logic [31:0] exp_beat(input logic [15:0] base, input int unsigned j);
    if (HDR == 1 && j == 0) return 32'hA500_0016;
    return {16'h0000, base} + 32'(j - HDR);
  endfunction

  task automatic add_row(input logic rst, input logic ena, input logic [15:0] base,
                         input logic rdy, input logic chk_v, input logic e_in_rdy,
                         input logic e_out_ena, input logic [31:0] e_v, input logic e_last);
    tbl[n_rows].rst         = rst;
    tbl[n_rows].ena         = ena;
    tbl[n_rows].base        = base;
    tbl[n_rows].rdy         = rdy;
    tbl[n_rows].chk_v       = chk_v;
    tbl[n_rows].exp_in_rdy  = e_in_rdy;
    tbl[n_rows].exp_out_ena = e_out_ena;
    tbl[n_rows].exp_v       = e_v;
    tbl[n_rows].exp_last    = e_last;
    n_rows++;
  endtask

  // All beats of a held frame; optional stall cycle before each beat and
  // optional new vector offered on the last-beat cycle.
  task automatic add_frame(input logic [15:0] base, input bit stall,
                           input bit chain, input logic [15:0] next_base);
    for (int unsigned j = 0; j < BEATS; j++) begin
      if (stall)
        add_row(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0,
                exp_beat(base, j), j == BEATS - 1);
      add_row(1'b0, chain && (j == BEATS - 1), next_base, 1'b1, 1'b1,
              j == BEATS - 1, 1'b1, exp_beat(base, j), j == BEATS - 1);
    end
  endtask

  task automatic idle_row();
    add_row(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic set_payload(input logic [15:0] base);
    for (int unsigned k = 0; k < WORDS; k++)
      in_v[k*WIDTH +: WIDTH] = {16'h0000, base} + 32'(k);
  endtask

  task automatic drive(input logic rst, input logic ena, input logic [15:0] base, input logic rdy);
    @(negedge CLK);
    RST     = rst;
    in_ena  = ena;
    out_rdy = rdy;
    if (ena) set_payload(base);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    n_rows  = 0;
    RST     = 1'b1;
    in_ena  = 1'b0;
    out_rdy = 1'b0;
    in_v    = '0;

    // Reset, then single frame at full rate.
    add_row(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    add_row(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle_row();
    add_row(1'b0, 1'b1, 16'h1000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add_frame(16'h1000, 1'b0, 1'b0, 16'h0);
    idle_row();
    // Stalled frame; vector accepted in IDLE even with downstream not ready.
    add_row(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add_frame(16'h2000, 1'b1, 1'b0, 16'h0);
    idle_row();
    // Back-to-back frames, second offered on the first frame's last beat.
    add_row(1'b0, 1'b1, 16'h3000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add_frame(16'h3000, 1'b0, 1'b1, 16'h4000);
    add_frame(16'h4000, 1'b0, 1'b0, 16'h0);
    idle_row();

    for (int i = 0; i < n_rows; i++) begin
      drive(tbl[i].rst, tbl[i].ena, tbl[i].base, tbl[i].rdy);
      check("in_rdy", i, 32'(in_rdy), 32'(tbl[i].exp_in_rdy));
      check("out_ena", i, 32'(out_ena), 32'(tbl[i].exp_out_ena));
      check("out_last", i, 32'(out_last), 32'(tbl[i].exp_last));
      if (tbl[i].chk_v)
        check("out_v", i, out_v, tbl[i].exp_v);
    end

    // Reset in the middle of a frame after six beats.
    drive(1'b0, 1'b1, 16'h5000, 1'b1);
    check("mid_cap_rdy", 0, 32'(in_rdy), 32'd1);
    for (int unsigned j = 0; j < 6; j++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      check("mid_beat_v", int'(j), out_v, exp_beat(16'h5000, j));
      check("mid_beat_ena", int'(j), 32'(out_ena), 32'd1);
    end
    drive(1'b1, 1'b0, 16'h0, 1'b1);
    check("mid_rst_in_rdy", 0, 32'(in_rdy), 32'd0);
    check("mid_rst_out_ena", 0, 32'(out_ena), 32'd0);
    check("mid_rst_last", 0, 32'(out_last), 32'd0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      check("post_rst_in_rdy", j, 32'(in_rdy), 32'd1);
      check("post_rst_out_ena", j, 32'(out_ena), 32'd0);
      check("post_rst_v", j, out_v, 32'h0);
    end
    // Next frame must start from its first beat.
    drive(1'b0, 1'b1, 16'h6000, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    check("new_frame_v", 0, out_v, exp_beat(16'h6000, 0));
    check("new_frame_ena", 0, 32'(out_ena), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
